sample_scheduler: RTL and testbench

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

---
 rtl/sample_scheduler.sv | 130 +++++++++++++
 tb/tb_sample_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_scheduler.sv
// Walks a square sample grid over a triangle's bounding box in raster order
// (x fastest), emitting one sample per cycle with a one-cycle accept latency.
module sample_scheduler #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     hold_R14H,
  output logic                     halt_R13H,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H,
  output logic                     state_dbg
);

  // Handshake: a triangle transfers on a rising edge where validTri_R13H=1 and
  // halt_R13H=0; hold_R14H=1 freezes every R14 output and the grid walk.
  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  state_t state, state_next;

  logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
  logic        [SIGFIG-1:0] step_q, step_sel;
  logic signed [SIGFIG:0]   x_next, y_next;
  logic                     x_last, y_last, last;
  logic                     accept, nonempty, load, advance, finish;

  always_comb begin
    step_sel = SIGFIG'(1) << RADIX;
    case (subSample_RnnnnU)
      4'b1000: step_sel = SIGFIG'(1) << RADIX;
      4'b0100: step_sel = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_sel = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_sel = SIGFIG'(1) << (RADIX - 3);
      default: step_sel = SIGFIG'(1) << RADIX;
    endcase
  end

  // One guard bit keeps x+step / y+step from wrapping near the positive limit.
  assign x_next = $signed({sample_R14S[0][SIGFIG-1], sample_R14S[0]}) + $signed({1'b0, step_q});
  assign y_next = $signed({sample_R14S[1][SIGFIG-1], sample_R14S[1]}) + $signed({1'b0, step_q});
  assign x_last = x_next > $signed({ur_x[SIGFIG-1], ur_x});
  assign y_last = y_next > $signed({ur_y[SIGFIG-1], ur_y});

  assign nonempty = (box_R13S[0][0] <= box_R13S[1][0]) && (box_R13S[0][1] <= box_R13S[1][1]);

  always_comb begin
    state_next = state;
    last       = 1'b0;
    halt_R13H  = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      WAIT: begin
        accept = validTri_R13H;
        load   = accept && nonempty;
        if (load) state_next = TEST;
      end
      TEST: begin
        last      = x_last && y_last;
        halt_R13H = !(last && !hold_R14H);
        accept    = validTri_R13H && !halt_R13H;
        load      = accept && nonempty;
        if (!hold_R14H) begin
          if (!last) begin
            advance = 1'b1;
          end else begin
            finish     = !load;
            state_next = load ? TEST : WAIT;
          end
        end
      end
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_next;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_R14S       <= '{default: '{default: '0}};
      color_R14U     <= '{default: '0};
      sample_R14S    <= '{default: '0};
      validSamp_R14H <= 1'b0;
      ll_x           <= '0;
      ll_y           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step_q         <= '0;
    end else if (load) begin
      tri_R14S       <= tri_R13S;
      color_R14U     <= color_R13U;
      ll_x           <= box_R13S[0][0];
      ll_y           <= box_R13S[0][1];
      ur_x           <= box_R13S[1][0];
      ur_y           <= box_R13S[1][1];
      step_q         <= step_sel;
      sample_R14S[0] <= box_R13S[0][0];
      sample_R14S[1] <= box_R13S[0][1];
      validSamp_R14H <= 1'b1;
    end else if (advance) begin
      if (!x_last) begin
        sample_R14S[0] <= x_next[SIGFIG-1:0];
      end else begin
        sample_R14S[0] <= ll_x;
        sample_R14S[1] <= y_next[SIGFIG-1:0];
      end
    end else if (finish) begin
      validSamp_R14H <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: grid walks, hold, empty box,
// back-to-back triangles, overflow guard and asynchronous reset.
module tb_sample_scheduler;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     hold_R14H;
  logic                     halt_R13H;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;
  logic                     state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt;

  always #5 clk = ~clk;

  sample_scheduler #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tri_R13S(tri_R13S),
    .color_R13U(color_R13U),
    .box_R13S(box_R13S),
    .validTri_R13H(validTri_R13H),
    .subSample_RnnnnU(subSample_RnnnnU),
    .hold_R14H(hold_R14H),
    .halt_R13H(halt_R13H),
    .tri_R14S(tri_R14S),
    .color_R14U(color_R14U),
    .sample_R14S(sample_R14S),
    .validSamp_R14H(validSamp_R14H),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] sub, input int id);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_R13S[v][a] = SIGFIG'(id * 100 + v * 4 + a);
    for (int c = 0; c < COLORS; c++) color_R13U[c] = SIGFIG'(id * 16 + c);
    box_R13S[0][0]   = SIGFIG'(llx);
    box_R13S[0][1]   = SIGFIG'(lly);
    box_R13S[1][0]   = SIGFIG'(urx);
    box_R13S[1][1]   = SIGFIG'(ury);
    subSample_RnnnnU = sub;
    validTri_R13H    = 1'b1;
  endtask

  task automatic expect_samp(input string tag, input int x, input int y);
    check({tag, ".valid"}, 32'(validSamp_R14H), 32'd1);
    check({tag, ".x"}, 32'(sample_R14S[0]), x);
    check({tag, ".y"}, 32'(sample_R14S[1]), y);
    if (validSamp_R14H) vcnt++;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 32'(validSamp_R14H), 32'd0);
    check({tag, ".halt"}, 32'(halt_R13H), 32'd0);
  endtask

  initial begin
    int xs [4] = '{0, 1024, 0, 1024};
    int ys [4] = '{0, 0, 1024, 1024};

    rst              = 1'b0;
    validTri_R13H    = 1'b0;
    hold_R14H        = 1'b0;
    subSample_RnnnnU = 4'b1000;
    tri_R13S         = '{default: '{default: '0}};
    color_R13U       = '{default: '0};
    box_R13S         = '{default: '{default: '0}};

    #2;
    expect_idle("reset");
    check("reset.x", 32'(sample_R14S[0]), 32'd0);
    check("reset.tri", 32'(tri_R14S[1][1]), 32'd0);
    check("reset.state", 32'(state_dbg), 32'd0);
    #20 rst = 1'b1;

    // single-point box
    tick();
    load_tri(1024, 2048, 1024, 2048, 4'b1000, 1);
    #1 check("t1.halt_wait", 32'(halt_R13H), 32'd0);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t1.s0", 1024, 2048);
    check("t1.halt_last", 32'(halt_R13H), 32'd0);
    check("t1.tri", 32'(tri_R14S[2][1]), 32'd109);
    check("t1.color", 32'(color_R14U[2]), 32'd18);
    tick();
    expect_idle("t1.end");

    // 2x2 grid at 1x
    load_tri(0, 0, 1024, 1024, 4'b1000, 2);
    tick();
    validTri_R13H = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_samp($sformatf("t2.s%0d", i), xs[i], ys[i]);
      check($sformatf("t2.halt%0d", i), 32'(halt_R13H), (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    expect_idle("t2.end");

    // 4x grid with a 3-cycle hold on the second sample
    load_tri(0, 0, 512, 512, 4'b0100, 3);
    tick();
    validTri_R13H = 1'b0;
    vcnt = 0;
    expect_samp("t3.s0", 0, 0);
    tick();
    expect_samp("t3.s1", 512, 0);
    hold_R14H = 1'b1;
    #1 check("t3.halt_hold", 32'(halt_R13H), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_samp($sformatf("t3.held%0d", i), 512, 0);
    end
    hold_R14H = 1'b0;
    tick();
    expect_samp("t3.s2", 0, 512);
    tick();
    expect_samp("t3.s3", 512, 512);
    tick();
    expect_idle("t3.end");
    check("t3.valid_cycles", 32'(vcnt), 32'd7);

    // empty box discarded, next triangle taken immediately
    load_tri(2048, 0, 1024, 0, 4'b1000, 4);
    #1 check("t4.halt_pre", 32'(halt_R13H), 32'd0);
    tick();
    expect_idle("t4.after_empty");
    load_tri(0, 0, 0, 0, 4'b1000, 5);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t4.next", 0, 0);
    check("t4.tri", 32'(tri_R14S[0][0]), 32'd500);
    tick();
    expect_idle("t4.end");

    // back-to-back: B waits during A, accepted on A's last edge
    load_tri(0, 0, 1024, 0, 4'b1000, 6);
    tick();
    load_tri(-1024, -1024, -1024, -1024, 4'b0001, 7);
    expect_samp("t5.a0", 0, 0);
    check("t5.halt_a0", 32'(halt_R13H), 32'd1);
    tick();
    expect_samp("t5.a1", 1024, 0);
    check("t5.tri_a", 32'(tri_R14S[0][0]), 32'd600);
    check("t5.halt_a1", 32'(halt_R13H), 32'd0);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t5.b0", -1024, -1024);
    check("t5.tri_b", 32'(tri_R14S[0][0]), 32'd700);
    tick();
    expect_idle("t5.end");

    // non-one-hot falls back to 1x; 64x stops at last point <= ur
    load_tri(0, 0, 1024, 0, 4'b0000, 8);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t6.s0", 0, 0);
    tick();
    expect_samp("t6.s1", 1024, 0);
    tick();
    expect_idle("t6.end");
    load_tri(0, 0, 200, 0, 4'b0001, 9);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t6.m0", 0, 0);
    tick();
    expect_samp("t6.m1", 128, 0);
    tick();
    expect_idle("t6.mend");

    // x+step past the positive limit must not wrap
    load_tri(8388507, 0, 8388607, 0, 4'b1000, 10);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t7.s0", 8388507, 0);
    check("t7.halt", 32'(halt_R13H), 32'd0);
    tick();
    expect_idle("t7.end");

    // asynchronous reset during the second sample
    load_tri(0, 0, 1024, 1024, 4'b1000, 11);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t8.s0", 0, 0);
    tick();
    expect_samp("t8.s1", 1024, 0);
    #1 rst = 1'b0;
    #1;
    expect_idle("t8.rst");
    check("t8.rst_x", 32'(sample_R14S[0]), 32'd0);
    check("t8.rst_tri", 32'(tri_R14S[0][0]), 32'd0);
    check("t8.rst_color", 32'(color_R14U[0]), 32'd0);
    #1 rst = 1'b1;
    load_tri(2048, 0, 3072, 0, 4'b1000, 12);
    tick();
    validTri_R13H = 1'b0;
    expect_samp("t8.n0", 2048, 0);
    tick();
    expect_samp("t8.n1", 3072, 0);
    tick();
    expect_idle("t8.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
